// File: rtl/dcache_maint_pkg.sv
// Shared types for the D-cache maintenance sequencer and the cache maintenance port.
package dcache_maint_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        WB    = 2'b01,
        INV   = 2'b10,
        WBINV = 2'b11
    } maint_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRAIN = 2'b01,
        ISSUE = 2'b10,
        DONE  = 2'b11
    } maint_state_t;

    // wb maps to bit0 and inv to bit1, so both together give WBINV
    function automatic maint_op_t req_op(input logic wb, input logic inv);
        return maint_op_t'({inv, wb});
    endfunction

endpackage

// File: rtl/dcache_maint_sequencer.sv
// Whole-cache maintenance sweep sequencer: parks the frontend, drains it, then walks
// every line index over the maintenance port; requests seen mid-sweep are replayed.
module dcache_maint_sequencer
    import dcache_maint_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_wb,
    input  logic                  start_inv,
    output logic                  busy,
    output logic                  done,
    output logic                  frontend_hold,
    input  logic                  frontend_idle,
    output logic                  maint_valid,
    output maint_op_t             maint_op,
    output logic [INDEX_BITS-1:0] maint_index,
    input  logic                  maint_ack
);

    localparam logic [INDEX_BITS-1:0] LAST_INDEX = '1;

    maint_state_t          state;
    maint_op_t             op_r;
    maint_op_t             pend_r;
    logic [INDEX_BITS-1:0] index_r;

    maint_op_t req;
    maint_op_t merged;

    assign req    = req_op(start_wb, start_inv);
    assign merged = maint_op_t'(pend_r | req);

    // Sweep FSM; every output is loaded together with the transition that defines it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_r          <= NONE;
            pend_r        <= NONE;
            index_r       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            frontend_hold <= 1'b0;
            maint_valid   <= 1'b0;
            maint_op      <= NONE;
            maint_index   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != NONE) begin
                        op_r          <= req;
                        state         <= DRAIN;
                        busy          <= 1'b1;
                        frontend_hold <= 1'b1;
                    end
                end
                DRAIN: begin
                    pend_r <= merged;
                    if (frontend_idle) begin
                        state       <= ISSUE;
                        index_r     <= '0;
                        maint_valid <= 1'b1;
                        maint_op    <= op_r;
                        maint_index <= '0;
                    end
                end
                ISSUE: begin
                    pend_r <= merged;
                    if (maint_ack) begin
                        if (index_r == LAST_INDEX) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            frontend_hold <= 1'b0;
                            maint_valid   <= 1'b0;
                            maint_op      <= NONE;
                            maint_index   <= '0;
                        end else begin
                            index_r     <= index_r + INDEX_BITS'(1);
                            maint_index <= index_r + INDEX_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    // A request landing in this very cycle joins the replayed opcode
                    pend_r <= NONE;
                    if (merged != NONE) begin
                        op_r          <= merged;
                        state         <= DRAIN;
                        frontend_hold <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_maint_sequencer.sv
// Scoreboard bench for dcache_maint_sequencer: directed timeline checks plus randomized
// sweeps with random drain delay, random ack and mid-sweep merges.
`timescale 1ns/1ps
module tb_dcache_maint_sequencer;

    localparam int unsigned INDEX_BITS = 2;
    localparam int          LINES      = 1 << INDEX_BITS;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start_wb;
    logic                  start_inv;
    logic                  busy;
    logic                  done;
    logic                  frontend_hold;
    logic                  frontend_idle;
    logic                  maint_valid;
    logic [1:0]            maint_op;
    logic [INDEX_BITS-1:0] maint_index;
    logic                  maint_ack;

    dcache_maint_sequencer #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk(clk), .reset(reset), .start_wb(start_wb), .start_inv(start_inv),
        .busy(busy), .done(done), .frontend_hold(frontend_hold), .frontend_idle(frontend_idle),
        .maint_valid(maint_valid), .maint_op(maint_op), .maint_index(maint_index),
        .maint_ack(maint_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]            op;
        logic [INDEX_BITS-1:0] idx;
    } cmd_t;

    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t exp_q[$];
    int   exp_done_q[$];
    logic [1:0] pend_model = 2'b00;

    int   stall_left = 0;
    int   stall_idx  = 0;
    bit   ack_rand   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sweep is LINES commands of one opcode, indices ascending, then one done
    function automatic void push_sweep(input logic [1:0] op);
        for (int i = 0; i < LINES; i++) exp_q.push_back(cmd_t'{op, INDEX_BITS'(i)});
        exp_done_q.push_back(32'(op));
    endfunction

    function automatic bit replay();
        if (pend_model == 2'b00) return 1'b0;
        push_sweep(pend_model);
        pend_model = 2'b00;
        return 1'b1;
    endfunction

    // Ack responder: optional forced stall on one index, otherwise always-ack or random
    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && maint_valid && 32'(maint_index) == stall_idx) begin
            maint_ack = 1'b0;
            stall_left--;
        end else if (ack_rand) begin
            maint_ack = 1'($urandom_range(0, 1));
        end else begin
            maint_ack = 1'b1;
        end
    end

    // Monitor
    cmd_t                  e_cmd;
    logic                  prev_stall = 1'b0;
    logic                  prev_done  = 1'b0;
    logic [1:0]            prev_op    = 2'b00;
    logic [INDEX_BITS-1:0] prev_idx   = '0;
    int                    cur_run    = 0;
    int                    sweep_cmds = 0;
    int                    done_count = 0;
    int                    last_run[LINES];

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            cur_run    = 0;
            sweep_cmds = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(maint_valid), 1);
                chk("stall_op", 32'(maint_op), 32'(prev_op));
                chk("stall_idx", 32'(maint_index), 32'(prev_idx));
            end
            if (maint_valid) begin
                chk("valid_hold", 32'(frontend_hold), 1);
                cur_run++;
                if (maint_ack) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_cmd: got op %0d idx %0d expected none at %0t",
                                 maint_op, maint_index, $time);
                    end else begin
                        e_cmd = exp_q.pop_front();
                        chk("cmd_op", 32'(maint_op), 32'(e_cmd.op));
                        chk("cmd_idx", 32'(maint_index), 32'(e_cmd.idx));
                    end
                    last_run[maint_index] = cur_run;
                    cur_run = 0;
                    sweep_cmds++;
                end
            end
            prev_stall = maint_valid && !maint_ack;
            prev_op    = maint_op;
            prev_idx   = maint_index;
            if (done) begin
                chk("done_pulse", 32'(prev_done), 0);
                chk("done_busy", 32'(busy), 1);
                chk("done_hold", 32'(frontend_hold), 0);
                chk("done_valid", 32'(maint_valid), 0);
                done_count++;
                if (exp_done_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got done expected none at %0t", $time);
                end else begin
                    void'(exp_done_q.pop_front());
                    chk("sweep_len", sweep_cmds, LINES);
                end
                sweep_cmds = 0;
            end
            prev_done = done;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic wb, input logic inv);
        push_sweep({inv, wb});
        start_wb  = wb;
        start_inv = inv;
        cycle();
        start_wb  = 1'b0;
        start_inv = 1'b0;
    endtask

    task automatic merge_req(input logic wb, input logic inv);
        pend_model |= {inv, wb};
        start_wb  = wb;
        start_inv = inv;
        cycle();
        start_wb  = 1'b0;
        start_inv = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cycle();
            n++;
        end
        if (done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done: got no done expected done within %0d cycles at %0t", budget, $time);
        end
    endtask

    task automatic finish_sweeps();
        wait_done(200);
        while (replay()) begin
            cycle();
            wait_done(200);
        end
        cycle();
        chk("idle_after_done", 32'(busy), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_hold"}, 32'(frontend_hold), 0);
        chk({tag, "_valid"}, 32'(maint_valid), 0);
        chk({tag, "_op"}, 32'(maint_op), 0);
        chk({tag, "_idx"}, 32'(maint_index), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        logic [1:0] op;
        logic [1:0] m;
        int nd;
        int r;

        reset = 1'b1; start_wb = 1'b0; start_inv = 1'b0;
        frontend_idle = 1'b1; maint_ack = 1'b0;
        cycle();
        cycle();
        chk_outputs_zero("reset");
        reset = 1'b0;
        cycle();

        // Reference timeline, WB, ack always high
        start_req(1'b1, 1'b0);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_hold", 32'(frontend_hold), 1);
        chk("t1_valid", 32'(maint_valid), 0);
        for (int k = 0; k < LINES; k++) begin
            cycle();
            chk("tl_valid", 32'(maint_valid), 1);
            chk("tl_idx", 32'(maint_index), k);
            chk("tl_op", 32'(maint_op), 1);
        end
        cycle();
        chk("tl_done", 32'(done), 1);
        chk("tl_done_hold", 32'(frontend_hold), 0);
        cycle();
        chk("tl_busy_low", 32'(busy), 0);
        chk("tl_done_low", 32'(done), 0);

        // Both requests in one cycle give WBINV and a single done
        dc0 = done_count;
        start_req(1'b1, 1'b1);
        cycle();
        chk("both_op", 32'(maint_op), 3);
        finish_sweeps();
        chk("both_done_count", done_count - dc0, 1);

        // Frontend busy for 5 cycles holds the sweep in DRAIN
        frontend_idle = 1'b0;
        start_req(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("drain_hold", 32'(frontend_hold), 1);
            chk("drain_valid", 32'(maint_valid), 0);
            cycle();
        end
        frontend_idle = 1'b1;
        chk("drain_still", 32'(maint_valid), 0);
        cycle();
        chk("drain_first_valid", 32'(maint_valid), 1);
        chk("drain_first_idx", 32'(maint_index), 0);
        finish_sweeps();

        // Ack withheld 3 cycles on index 1
        stall_idx = 1;
        stall_left = 3;
        start_req(1'b1, 1'b0);
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("stall_hold_idx", 32'(maint_index), 1);
            chk("stall_hold_op", 32'(maint_op), 1);
        end
        cycle();
        chk("stall_next_idx", 32'(maint_index), 2);
        finish_sweeps();
        chk("stall_run_idx1", last_run[1], 4);
        chk("stall_run_idx2", last_run[2], 1);

        // INV arrives during a WB sweep at index 2: replayed right after done
        dc0 = done_count;
        start_req(1'b1, 1'b0);
        cycle(); cycle(); cycle();
        chk("merge_at_idx", 32'(maint_index), 2);
        merge_req(1'b0, 1'b1);
        cycle();
        chk("merge_done", 32'(done), 1);
        void'(replay());
        cycle();
        chk("replay_drain_hold", 32'(frontend_hold), 1);
        chk("replay_drain_busy", 32'(busy), 1);
        chk("replay_drain_valid", 32'(maint_valid), 0);
        finish_sweeps();
        chk("merge_done_count", done_count - dc0, 2);

        // Pending WB plus an INV arriving in the DONE cycle replay as WBINV
        start_req(1'b0, 1'b1);
        cycle();
        merge_req(1'b1, 1'b0);
        cycle(); cycle(); cycle();
        chk("donecyc_done", 32'(done), 1);
        merge_req(1'b0, 1'b1);
        void'(replay());
        chk("donecyc_hold", 32'(frontend_hold), 1);
        finish_sweeps();

        // Reset mid-ISSUE at index 2 aborts the sweep for good
        start_req(1'b1, 1'b0);
        cycle(); cycle(); cycle();
        chk("rst_pre_idx", 32'(maint_index), 2);
        reset = 1'b1;
        #1;
        chk_outputs_zero("rst_async");
        exp_q.delete();
        exp_done_q.delete();
        pend_model = 2'b00;
        cycle();
        cycle();
        reset = 1'b0;
        dc0 = done_count;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("rst_idle_busy", 32'(busy), 0);
            chk("rst_idle_done", 32'(done), 0);
        end
        chk("rst_no_done", done_count - dc0, 0);
        start_req(1'b1, 1'b0);
        cycle();
        chk("rst_restart_idx", 32'(maint_index), 0);
        chk("rst_restart_valid", 32'(maint_valid), 1);
        finish_sweeps();

        // Randomized sweeps: random drain delay, random acks, optional mid-sweep merge
        ack_rand = 1'b1;
        for (int it = 0; it < 30; it++) begin
            op = 2'($urandom_range(1, 3));
            nd = $urandom_range(0, 4);
            frontend_idle = (nd == 0);
            start_req(op[0], op[1]);
            for (int k = 0; k < nd; k++) begin
                chk("rnd_drain_hold", 32'(frontend_hold), 1);
                chk("rnd_drain_valid", 32'(maint_valid), 0);
                cycle();
            end
            frontend_idle = 1'b1;
            cycle();
            chk("rnd_first_valid", 32'(maint_valid), 1);
            chk("rnd_first_idx", 32'(maint_index), 0);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 3);
                repeat (r) cycle();
                m = 2'($urandom_range(1, 3));
                merge_req(m[0], m[1]);
            end
            finish_sweeps();
        end

        chk("exp_cmds_left", exp_q.size(), 0);
        chk("exp_dones_left", exp_done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
